// File: rtl/lights_pkg.sv
// Shared widths, colour field positions and the per-period fade step used by
// the RGB PWM driver and its channels.
package lights_pkg;

  localparam int CH_W  = 8;
  localparam int RGB_W = 24;
  localparam int PSC_W = 16;

  localparam int RED_HI   = 23;
  localparam int RED_LO   = 16;
  localparam int GREEN_HI = 15;
  localparam int GREEN_LO = 8;
  localparam int BLUE_HI  = 7;
  localparam int BLUE_LO  = 0;

  localparam logic [RGB_W-1:0] WHITE   = 24'hFFFF_FF;
  localparam logic [CH_W-1:0]  CNT_MAX = 8'hFF;

  // One step toward the target; saturation comes for free because we only
  // move when the target lies strictly beyond the current value.
  function automatic logic [CH_W-1:0] fade_step(input logic [CH_W-1:0] cur,
                                                input logic [CH_W-1:0] tgt);
    logic [CH_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt)      nxt = cur + 8'd1;
    else if (cur > tgt) nxt = cur - 8'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour-in / PWM-out bundle of the RGB PWM driver. There is no handshake:
// light is a level the driver samples at its own period boundaries, and the
// outputs are free-running registered levels plus a one-cycle period pulse.
interface rgb_pwm_driver_if;
  import lights_pkg::*;

  logic             enable;
  logic [RGB_W-1:0] light;
  logic             pwm_r;
  logic             pwm_g;
  logic             pwm_b;
  logic [RGB_W-1:0] current;
  logic             period_start;

  modport master (
    output enable, light,
    input  pwm_r, pwm_g, pwm_b, current, period_start
  );

  modport slave (
    input  enable, light,
    output pwm_r, pwm_g, pwm_b, current, period_start
  );

endinterface

// File: rtl/pwm_channel.sv
// One colour channel: duty register updated only at period boundaries (jump or
// fade), compared against the shared PWM counter into a registered pin.
module pwm_channel
  import lights_pkg::*;
#(
  parameter bit FADE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            boundary,
  input  logic [CH_W-1:0] target,
  input  logic [CH_W-1:0] cnt,
  output logic [CH_W-1:0] current,
  output logic            pwm
);

  logic [CH_W-1:0] current_q, current_d;
  logic            pwm_q, pwm_d;

  // The compare uses the pre-edge duty, so a boundary update lands exactly
  // when the counter restarts at 0 and no period is ever mixed.
  always_comb begin
    current_d = current_q;
    if (boundary) begin
      current_d = FADE_EN ? fade_step(current_q, target) : target;
    end
    pwm_d = enable && (current_q > cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      current_q <= current_d;
      pwm_q     <= pwm_d;
    end
  end

  assign current = current_q;
  assign pwm     = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver: prescaler and 8-bit period counter shared by
// three pwm_channel instances, with a registered period_start pulse.
module rgb_pwm_driver
  import lights_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned FADE_EN  = 1
) (
  input logic              clk,
  input logic              rst,
  rgb_pwm_driver_if.slave  bus
);

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam bit               FADE_BIT = (FADE_EN != 0);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CH_W-1:0]  cnt_q, cnt_d;
  logic             ps_q, ps_d;
  logic             tick;
  logic             boundary;

  logic [CH_W-1:0]  cur_r, cur_g, cur_b;

  // Disable overrides everything, including a boundary in the same cycle.
  always_comb begin
    tick     = bus.enable && (psc_q == PSC_LAST);
    boundary = tick && (cnt_q == CNT_MAX);
    psc_d    = tick ? '0 : psc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
    ps_d     = boundary;
    if (!bus.enable) begin
      psc_d = '0;
      cnt_d = '0;
      ps_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  pwm_channel #(.FADE_EN(FADE_BIT)) u_red (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .boundary (boundary),
    .target   (bus.light[RED_HI:RED_LO]),
    .cnt      (cnt_q),
    .current  (cur_r),
    .pwm      (bus.pwm_r)
  );

  pwm_channel #(.FADE_EN(FADE_BIT)) u_green (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .boundary (boundary),
    .target   (bus.light[GREEN_HI:GREEN_LO]),
    .cnt      (cnt_q),
    .current  (cur_g),
    .pwm      (bus.pwm_g)
  );

  pwm_channel #(.FADE_EN(FADE_BIT)) u_blue (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .boundary (boundary),
    .target   (bus.light[BLUE_HI:BLUE_LO]),
    .cnt      (cnt_q),
    .current  (cur_b),
    .pwm      (bus.pwm_b)
  );

  assign bus.current      = {cur_r, cur_g, cur_b};
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: three instances (jump/PRESCALE=1,
// fade/PRESCALE=1, jump/PRESCALE=4) sharing clock and reset.
module tb_rgb_pwm_driver;
  import lights_pkg::*;

  logic clk;
  logic rst;

  rgb_pwm_driver_if if0 ();
  rgb_pwm_driver_if if1 ();
  rgb_pwm_driver_if if2 ();

  rgb_pwm_driver #(.PRESCALE(1), .FADE_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rgb_pwm_driver #(.PRESCALE(1), .FADE_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rgb_pwm_driver #(.PRESCALE(4), .FADE_EN(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [23:0] light;
    int          hr;
    int          hg;
    int          hb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic ps_of(input int d);
    case (d)
      0:       return if0.period_start;
      1:       return if1.period_start;
      default: return if2.period_start;
    endcase
  endfunction

  // Advance to the next negedge showing period_start; n = negedges waited.
  task automatic wait_ps(input string name, input int d, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps_of(d) && n < max);
    check({name, "_ps_seen"}, 32'(ps_of(d)), 32'd1);
  endtask

  // One full dut0 period after a period_start negedge: pin k reflects counter k-1.
  task automatic measure0(input string name, input int er, input int eg, input int eb);
    int hr, hg, hb, np;
    hr = 0; hg = 0; hb = 0; np = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      hr += int'(if0.pwm_r);
      hg += int'(if0.pwm_g);
      hb += int'(if0.pwm_b);
      if (k < 256) np += int'(if0.period_start);
    end
    check({name, "_hi_r"}, hr, er);
    check({name, "_hi_g"}, hg, eg);
    check({name, "_hi_b"}, hb, eb);
    check({name, "_ps_mid"}, np, 0);
    check({name, "_ps_end"}, 32'(if0.period_start), 32'd1);
  endtask

  initial begin
    int n, act;

    vecs[0] = '{24'h804000, 128, 64, 0};
    vecs[1] = '{WHITE,      255, 255, 255};
    vecs[2] = '{24'h000000, 0,   0,   0};
    vecs[3] = '{24'h01FE7F, 1,   254, 127};
    vecs[4] = '{24'h7F0180, 127, 1,   128};

    rst = 1'b0;
    if0.enable = 1'b0; if0.light = '0;
    if1.enable = 1'b0; if1.light = '0;
    if2.enable = 1'b0; if2.light = '0;

    repeat (3) @(negedge clk);
    check("rst_cur0", if0.current, 32'h0);
    check("rst_pins0", {if0.pwm_r, if0.pwm_g, if0.pwm_b, if0.period_start}, 32'h0);
    check("rst_cur2", if2.current, 32'h0);
    rst = 1'b1;

    // idle: nothing moves while disabled
    act = 0;
    if0.light = WHITE;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      act += int'(if0.pwm_r | if0.pwm_g | if0.pwm_b | if0.period_start);
    end
    check("idle_quiet", act, 0);
    check("idle_cur", if0.current, 32'h0);

    // table: jump mode duty per colour
    if0.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if0.light = vecs[i].light;
      wait_ps($sformatf("vec%0d", i), 0, 600, n);
      check($sformatf("vec%0d_cur", i), if0.current, 32'(vecs[i].light));
      measure0($sformatf("vec%0d", i), vecs[i].hr, vecs[i].hg, vecs[i].hb);
    end

    // disable at PWM counter 100, then re-enable
    if0.light = 24'h804000;
    wait_ps("dis", 0, 600, n);
    check("dis_n", n, 256);
    repeat (100) @(negedge clk);
    check("dis_pre_r", 32'(if0.pwm_r), 32'd1);
    if0.enable = 1'b0;
    if0.light  = 24'h000000;
    @(negedge clk);
    check("dis_pins", {if0.pwm_r, if0.pwm_g, if0.pwm_b, if0.period_start}, 32'h0);
    check("dis_cur", if0.current, 32'h804000);
    act = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      act += int'(if0.pwm_r | if0.pwm_g | if0.pwm_b | if0.period_start);
    end
    check("dis_quiet", act, 0);
    check("dis_cur_hold", if0.current, 32'h804000);
    if0.light  = WHITE;
    if0.enable = 1'b1;
    wait_ps("reen", 0, 600, n);
    check("reen_n", n, 256);
    check("reen_cur", if0.current, 32'(WHITE));

    // enable drops on the cycle that would be the boundary
    if0.light = 24'h000000;
    repeat (255) @(negedge clk);
    if0.enable = 1'b0;
    @(negedge clk);
    check("coin_ps", 32'(if0.period_start), 32'd0);
    check("coin_cur", if0.current, 32'(WHITE));
    repeat (3) @(negedge clk);
    if0.light  = 24'h804000;
    if0.enable = 1'b1;
    wait_ps("coin_re", 0, 600, n);
    check("coin_re_n", n, 256);
    check("coin_re_cur", if0.current, 32'h804000);

    // PRESCALE=4: 1024-cycle period, one-cycle pulse, mid-period light ignored
    if2.light  = 24'h123456;
    if2.enable = 1'b1;
    wait_ps("p4a", 2, 1100, n);
    check("p4a_n", n, 1024);
    check("p4a_cur", if2.current, 32'h123456);
    @(negedge clk);
    check("p4a_width", 32'(if2.period_start), 32'd0);
    repeat (499) @(negedge clk);
    if2.light = 24'hAABBCC;
    repeat (10) @(negedge clk);
    check("p4_mid_cur", if2.current, 32'h123456);
    wait_ps("p4b", 2, 1100, n);
    check("p4b_n", n, 514);
    check("p4b_cur", if2.current, 32'hAABBCC);
    if2.enable = 1'b0;

    // fade from 0 toward 03FF01, then reverse red/blue
    if1.light  = 24'h03FF01;
    if1.enable = 1'b1;
    for (int b = 1; b <= 258; b++) begin
      if (b == 257) if1.light = 24'h01FF03;
      wait_ps($sformatf("fade%0d", b), 1, 300, n);
      case (b)
        1:   begin check("fade1_n", n, 256); check("fade1", if1.current, 32'h010101); end
        2:   check("fade2", if1.current, 32'h020201);
        3:   begin check("fade3_n", n, 256); check("fade3", if1.current, 32'h030301); end
        254: check("fade254", if1.current, 32'h03FE01);
        255: check("fade255", if1.current, 32'h03FF01);
        256: check("fade256", if1.current, 32'h03FF01);
        257: check("fade257", if1.current, 32'h02FF02);
        258: check("fade258", if1.current, 32'h01FF03);
        default: ;
      endcase
    end

    // asynchronous reset mid-period
    wait_ps("prerst", 0, 600, n);
    repeat (10) @(negedge clk);
    check("prerst_r", 32'(if0.pwm_r), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_cur0", if0.current, 32'h0);
    check("arst_pins0", {if0.pwm_r, if0.pwm_g, if0.pwm_b, if0.period_start}, 32'h0);
    check("arst_cur1", if1.current, 32'h0);
    repeat (3) @(negedge clk);
    if1.light = 24'h03FF01;
    rst = 1'b1;
    wait_ps("rec", 0, 600, n);
    check("rec_n", n, 256);
    check("rec_cur0", if0.current, 32'h804000);
    check("rec_cur1", if1.current, 32'h010101);
    measure0("rec", 128, 64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles per PWM tick; legal range 1..65535.
REQ-002 Parameter FADE_EN, default 1: 1 = step toward target per period, 0 = jump to target.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: 1 = run PWM, 0 = idle.
REQ-006 Port light  input  24: target colour; [23:16] red, [15:8] green, [7:0] blue.
REQ-007 Port pwm_r  output  1: red PWM drive, registered.
REQ-008 Port pwm_g  output  1: green PWM drive, registered.
REQ-009 Port pwm_b  output  1: blue PWM drive, registered.
REQ-010 Port current  output  24: duty values in use this period, same packing as light.
REQ-011 Port period_start  output  1: one-cycle pulse at each PWM period boundary.

Function
REQ-012 Prescale counter: 0..PRESCALE-1, wraps; tick asserted in the cycle it equals PRESCALE-1.
REQ-013 PWM counter: 8-bit, +1 per tick, wraps 255->0; one period = 256 ticks = 256*PRESCALE clk.
REQ-014 Boundary event: tick while PWM counter = 255; period_start = 1 in the following cycle only.
REQ-015 light is sampled only on the boundary event; changes mid-period have no effect until the next boundary.
REQ-016 FADE_EN=0: on boundary, current <= light.
REQ-017 FADE_EN=1: on boundary, per channel independently: current < target -> +1; current > target -> -1; equal -> hold.
REQ-018 No wrap in fade arithmetic; 8-bit unsigned, 0x00 and 0xFF never over/underflow.
REQ-019 pwm_x next = enable AND (current_x > PWM counter); 1 clk latency from counter to pin.
REQ-020 Duty: current_x=0x00 -> constant 0; 0xFF -> high 255 of 256 ticks; N -> high N ticks, starting at counter 0.
REQ-021 Updated current takes effect from PWM counter 0 of the new period; no glitch or partial period.
REQ-022 enable=0: prescale and PWM counters held at 0, pwm_r/g/b = 0, period_start = 0, current holds value.
REQ-023 enable 0->1: counting starts from 0; first boundary after exactly 256*PRESCALE enabled cycles.
REQ-024 enable dropped mid-period: counters cleared next cycle, outputs low next cycle; no boundary update occurs.
REQ-025 Boundary coincident with enable falling: enable wins; no update, no period_start.

Reset
REQ-026 rst low: immediately clear prescale counter, PWM counter, current (0x000000), pwm_r/g/b (0), period_start (0).
REQ-027 rst release: synchronous to clk on deassertion; first counting cycle is the first edge with rst high and enable high.
REQ-028 Reset mid-fade: fade progress lost; restarts from 0x000000 toward sampled light.

Structure
REQ-029 Shared package lights_pkg: CH_W=8, RGB_W=24, field-slice constants RED/GREEN/BLUE hi/lo, white constant 24'hFFFFFF.
REQ-030 One sub-module pwm_channel (8-bit current register, fade stepper, comparator, output register), instantiated 3 times; counters and prescaler live in the top.

Verification
REQ-031 PRESCALE=1, FADE_EN=0, light=0x804000, enable=1 -> after first boundary, pwm_r high 128 of 256 clk, pwm_g 64, pwm_b 0.
REQ-032 light=0xFFFFFF, FADE_EN=0 -> each pin low exactly 1 tick per period; light=0x000000 -> pins never high.
REQ-033 FADE_EN=1, current=0x000000, light=0x03FF01 -> after 3 boundaries current=0x030301; after 255 boundaries 0x03FF01; then holds.
REQ-034 PRESCALE=4 -> period_start pulses every 1024 clk, width 1 clk; mid-period light change reflected only after next pulse.
REQ-035 enable low at PWM counter 100 -> pins 0 next cycle, current unchanged; re-enable -> first period_start 256*PRESCALE cycles later.
REQ-036 rst asserted asynchronously mid-period (between clk edges) -> all outputs 0 before next clk edge; recovery per REQ-027.
